// File: rtl/cnt_seq_ctrl.sv
// cnt_seq_ctrl: sequencing controller around a WIDTH-bit up-counter.
// Turns start/stop/pause requests into a programmable-period timer with
// one-shot and auto-reload modes, a terminal-count tick and a done pulse.
// Optional build macro: CNT_SEQ_CTRL_PRESCALE_EN adds a PRESCALE-cycle
// prescaler that gates every counter step while running.
module cnt_seq_ctrl #(
  parameter int WIDTH = 4
`ifdef CNT_SEQ_CTRL_PRESCALE_EN
  , parameter int PRESCALE = 4
`endif
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic             i_pause,
  input  logic             i_mode,
  input  logic [WIDTH-1:0] i_period,
  output logic [WIDTH-1:0] o_cnt,
  output logic             o_busy,
  output logic             o_tick,
  output logic             o_done,
  output logic [1:0]       o_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             mode_q, mode_d;
  logic             at_period;
  logic             step;

  assign at_period = (cnt_q == period_q);

`ifdef CNT_SEQ_CTRL_PRESCALE_EN
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] pre_q;
  logic          pre_clr;
  logic          pre_adv;

  assign step    = (pre_q == PW'(PRESCALE - 1));
  assign pre_clr = ((state_q == IDLE) && i_start) ||
                   (((state_q == RUN) || (state_q == PAUSE)) && i_stop);
  assign pre_adv = (state_q == RUN) && !i_stop && !i_pause;

  // Prescaler: clears on start/stop, advances only on live RUN cycles, frozen otherwise
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pre_q <= '0;
    end else if (pre_clr) begin
      pre_q <= '0;
    end else if (pre_adv) begin
      pre_q <= step ? '0 : pre_q + PW'(1);
    end
  end
`else
  assign step = 1'b1;
`endif

  // State, counter and latched start-time configuration registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      period_q <= '0;
      mode_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      mode_q   <= mode_d;
    end
  end

  // Next-state and counter update; stop beats pause beats terminal count
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    mode_d   = mode_q;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          period_d = i_period;
          mode_d   = i_mode;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (i_stop) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (i_pause) begin
          state_d = PAUSE;
        end else if (step) begin
          if (at_period) begin
            if (mode_q) begin
              cnt_d = '0;
            end else begin
              state_d = DONE;
            end
          end else begin
            cnt_d = cnt_q + WIDTH'(1);
          end
        end
      end
      PAUSE: begin
        if (i_stop) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (!i_pause) begin
          state_d = RUN;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign o_cnt   = cnt_q;
  assign o_state = state_q;
  assign o_busy  = (state_q == RUN) || (state_q == PAUSE);
  assign o_done  = (state_q == DONE);
  assign o_tick  = (state_q == RUN) && at_period && !i_stop && !i_pause && step;

endmodule

// File: tb/tb_cnt_seq_ctrl.sv
// tb_cnt_seq_ctrl: self-checking bench for cnt_seq_ctrl (WIDTH=4, default build).
// Expected outputs come from an arithmetic model: the count is derived from
// the number of live RUN cycles since start, modulo P+1 or saturating at P.
module tb_cnt_seq_ctrl;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic       i_start;
  logic       i_stop;
  logic       i_pause;
  logic       i_mode;
  logic [3:0] i_period;
  logic [3:0] o_cnt;
  logic       o_busy;
  logic       o_tick;
  logic       o_done;
  logic [1:0] o_state;

  int n_compared   = 0;
  int n_mismatched = 0;

  cnt_seq_ctrl #(.WIDTH(4)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_start (i_start),
    .i_stop  (i_stop),
    .i_pause (i_pause),
    .i_mode  (i_mode),
    .i_period(i_period),
    .o_cnt   (o_cnt),
    .o_busy  (o_busy),
    .o_tick  (o_tick),
    .o_done  (o_done),
    .o_state (o_state)
  );

  always #5 i_clk = ~i_clk;

  // Outputs packed as {state, cnt, busy, tick, done}
  function automatic logic [8:0] pack(input int st, input int cnt, input bit busy,
                                      input bit tick, input bit done);
    return {2'(st), 4'(cnt), busy, tick, done};
  endfunction

  task automatic next_cycle;
    @(posedge i_clk);
    #1;
  endtask

  task automatic start_run(input int p, input bit mode);
    i_start  = 1'b1;
    i_mode   = mode;
    i_period = 4'(p);
    i_stop   = 1'b0;
    i_pause  = 1'b0;
    next_cycle();
    i_start  = 1'b0;
  endtask

  task automatic test_reset;
    logic [8:0] got;
    i_rst_n = 1'b0;
    i_start = 1'b0; i_stop = 1'b0; i_pause = 1'b0; i_mode = 1'b0; i_period = 4'd0;
    #2;
    got = {o_state, o_cnt, o_busy, o_tick, o_done};
    n_compared++;
    if (got !== pack(0, 0, 0, 0, 0)) begin
      n_mismatched++;
      $display("[TB] FAIL reset_assert got=%b want=%b", got, pack(0, 0, 0, 0, 0));
    end
    next_cycle();
    i_rst_n = 1'b1;
    i_start = 1'b0;
    @(negedge i_clk);
    got = {o_state, o_cnt, o_busy, o_tick, o_done};
    n_compared++;
    if (got !== pack(0, 0, 0, 0, 0)) begin
      n_mismatched++;
      $display("[TB] FAIL reset_release got=%b want=%b", got, pack(0, 0, 0, 0, 0));
    end
    next_cycle();
  endtask

  // One-shot run with random ignored start/period/mode activity while busy
  task automatic test_oneshot(input int p);
    logic [8:0] got, want;
    start_run(p, 1'b0);
    for (int k = 1; k <= p + 1; k++) begin
      i_start  = 1'($urandom);
      i_period = 4'($urandom);
      i_mode   = 1'($urandom);
      want = pack(1, k - 1, 1, (k == p + 1), 0);
      @(negedge i_clk);
      got = {o_state, o_cnt, o_busy, o_tick, o_done};
      n_compared++;
      if (got !== want) begin
        n_mismatched++;
        $display("[TB] FAIL oneshot_run p=%0d k=%0d got=%b want=%b", p, k, got, want);
      end
      next_cycle();
    end
    i_start = 1'b1;
    want = pack(3, p, 0, 0, 1);
    @(negedge i_clk);
    got = {o_state, o_cnt, o_busy, o_tick, o_done};
    n_compared++;
    if (got !== want) begin
      n_mismatched++;
      $display("[TB] FAIL oneshot_done p=%0d got=%b want=%b", p, got, want);
    end
    next_cycle();
    i_start = 1'b0;
    want = pack(0, p, 0, 0, 0);
    @(negedge i_clk);
    got = {o_state, o_cnt, o_busy, o_tick, o_done};
    n_compared++;
    if (got !== want) begin
      n_mismatched++;
      $display("[TB] FAIL oneshot_idle p=%0d got=%b want=%b", p, got, want);
    end
    next_cycle();
  endtask

  // Auto-reload for ncyc cycles, then a stop that must suppress any tick
  task automatic test_autoreload(input int p, input int ncyc);
    logic [8:0] got, want;
    start_run(p, 1'b1);
    for (int k = 1; k <= ncyc; k++) begin
      i_period = 4'($urandom);
      i_mode   = 1'($urandom);
      want = pack(1, (k - 1) % (p + 1), 1, ((k - 1) % (p + 1)) == p, 0);
      @(negedge i_clk);
      got = {o_state, o_cnt, o_busy, o_tick, o_done};
      n_compared++;
      if (got !== want) begin
        n_mismatched++;
        $display("[TB] FAIL reload_run p=%0d k=%0d got=%b want=%b", p, k, got, want);
      end
      next_cycle();
    end
    i_stop = 1'b1;
    want = pack(1, ncyc % (p + 1), 1, 0, 0);
    @(negedge i_clk);
    got = {o_state, o_cnt, o_busy, o_tick, o_done};
    n_compared++;
    if (got !== want) begin
      n_mismatched++;
      $display("[TB] FAIL reload_stop p=%0d got=%b want=%b", p, got, want);
    end
    next_cycle();
    i_stop = 1'b0;
    want = pack(0, 0, 0, 0, 0);
    @(negedge i_clk);
    got = {o_state, o_cnt, o_busy, o_tick, o_done};
    n_compared++;
    if (got !== want) begin
      n_mismatched++;
      $display("[TB] FAIL reload_after_stop p=%0d got=%b want=%b", p, got, want);
    end
    next_cycle();
  endtask

  // Auto-reload with pause either from a fixed mask or random; ends with a stop
  task automatic test_pause(input int p, input int ncyc, input bit rnd, input logic [31:0] mask);
    logic [8:0] got, want;
    int  n      = 0;
    bit  paused = 1'b0;
    int  cnt;
    start_run(p, 1'b1);
    for (int k = 1; k <= ncyc; k++) begin
      i_pause = rnd ? ($urandom_range(0, 2) == 0) : mask[k];
      cnt  = n % (p + 1);
      want = pack(paused ? 2 : 1, cnt, 1, !paused && !i_pause && (cnt == p), 0);
      @(negedge i_clk);
      got = {o_state, o_cnt, o_busy, o_tick, o_done};
      n_compared++;
      if (got !== want) begin
        n_mismatched++;
        $display("[TB] FAIL pause_run p=%0d k=%0d pause=%0b got=%b want=%b",
                 p, k, i_pause, got, want);
      end
      if (!paused) begin
        if (i_pause) paused = 1'b1;
        else         n++;
      end else if (!i_pause) begin
        paused = 1'b0;
      end
      next_cycle();
    end
    i_stop  = 1'b1;
    i_pause = 1'($urandom);
    want = pack(paused ? 2 : 1, n % (p + 1), 1, 0, 0);
    @(negedge i_clk);
    got = {o_state, o_cnt, o_busy, o_tick, o_done};
    n_compared++;
    if (got !== want) begin
      n_mismatched++;
      $display("[TB] FAIL pause_stop p=%0d got=%b want=%b", p, got, want);
    end
    next_cycle();
    i_stop  = 1'b0;
    i_pause = 1'b0;
    want = pack(0, 0, 0, 0, 0);
    @(negedge i_clk);
    got = {o_state, o_cnt, o_busy, o_tick, o_done};
    n_compared++;
    if (got !== want) begin
      n_mismatched++;
      $display("[TB] FAIL pause_after_stop p=%0d got=%b want=%b", p, got, want);
    end
    next_cycle();
  endtask

  // One-shot stopped exactly in the terminal-count cycle
  task automatic test_stop_at_terminal(input int p);
    logic [8:0] got, want;
    start_run(p, 1'b0);
    for (int k = 1; k <= p; k++) next_cycle();
    i_stop = 1'b1;
    want = pack(1, p, 1, 0, 0);
    @(negedge i_clk);
    got = {o_state, o_cnt, o_busy, o_tick, o_done};
    n_compared++;
    if (got !== want) begin
      n_mismatched++;
      $display("[TB] FAIL stop_terminal p=%0d got=%b want=%b", p, got, want);
    end
    next_cycle();
    i_stop = 1'b0;
    want = pack(0, 0, 0, 0, 0);
    @(negedge i_clk);
    got = {o_state, o_cnt, o_busy, o_tick, o_done};
    n_compared++;
    if (got !== want) begin
      n_mismatched++;
      $display("[TB] FAIL stop_terminal_next p=%0d got=%b want=%b", p, got, want);
    end
    next_cycle();
  endtask

  // Reset dropped between clock edges must clear outputs without an edge
  task automatic test_async_reset;
    logic [8:0] got;
    start_run(9, 1'b1);
    repeat (4) next_cycle();
    #2;
    i_rst_n = 1'b0;
    #1;
    got = {o_state, o_cnt, o_busy, o_tick, o_done};
    n_compared++;
    if (got !== pack(0, 0, 0, 0, 0)) begin
      n_mismatched++;
      $display("[TB] FAIL async_reset got=%b want=%b", got, pack(0, 0, 0, 0, 0));
    end
    next_cycle();
    i_rst_n = 1'b1;
    @(negedge i_clk);
    got = {o_state, o_cnt, o_busy, o_tick, o_done};
    n_compared++;
    if (got !== pack(0, 0, 0, 0, 0)) begin
      n_mismatched++;
      $display("[TB] FAIL async_reset_release got=%b want=%b", got, pack(0, 0, 0, 0, 0));
    end
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_oneshot(5);
    test_oneshot(0);
    test_oneshot(15);
    for (int r = 0; r < 3; r++) test_oneshot($urandom_range(0, 15));
    test_autoreload(3, 14);
    test_autoreload(15, 34);
    test_autoreload(0, 6);
    for (int r = 0; r < 3; r++) test_autoreload($urandom_range(0, 15), $urandom_range(1, 40));
    test_pause(5, 12, 1'b0, 32'h0000_0038);
    for (int r = 0; r < 4; r++) test_pause($urandom_range(0, 6), 30, 1'b1, 32'h0);
    test_stop_at_terminal(5);
    test_stop_at_terminal(0);
    test_stop_at_terminal($urandom_range(1, 15));
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
